// File: rtl/rs_station.sv
// Reservation station: holds micro-ops until both operands resolve, snoops ALU/LSB CDBs,
// issues one ready op per cycle to a registered ALU port. Optional RS_AGE_SELECT_EN = oldest-first.
module rs_station #(
    parameter int RS_SIZE = 16,
    parameter int ROB_W   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             ISSUE_sgn,
    input  logic [5:0]       ISSUE_opcode,
    input  logic [ROB_W-1:0] ISSUE_ROB_name,
    input  logic [31:0]      ISSUE_Vj,
    input  logic [31:0]      ISSUE_Vk,
    input  logic             ISSUE_Qj_busy,
    input  logic             ISSUE_Qk_busy,
    input  logic [ROB_W-1:0] ISSUE_Qj,
    input  logic [ROB_W-1:0] ISSUE_Qk,
    output logic             RS_full,
    input  logic             ALU_CDB_sgn,
    input  logic [31:0]      ALU_CDB_result,
    input  logic [ROB_W-1:0] ALU_CDB_ROB_name,
    input  logic             LSB_CDB_sgn,
    input  logic [31:0]      LSB_CDB_result,
    input  logic [ROB_W-1:0] LSB_CDB_ROB_name,
    input  logic             ROB_clear,
    output logic             ALU_sgn,
    output logic [5:0]       ALU_opcode,
    output logic [ROB_W-1:0] ALU_ROB_name,
    output logic [31:0]      ALU_lhs,
    output logic [31:0]      ALU_rhs
);
    localparam int IDX_W = $clog2(RS_SIZE);

    logic [RS_SIZE-1:0] busy, qj_busy, qk_busy, ready;
    logic [5:0]         op_q  [RS_SIZE];
    logic [ROB_W-1:0]   rob_q [RS_SIZE];
    logic [ROB_W-1:0]   qj    [RS_SIZE];
    logic [ROB_W-1:0]   qk    [RS_SIZE];
    logic [31:0]        vj    [RS_SIZE];
    logic [31:0]        vk    [RS_SIZE];

    logic             free_vld, sel_vld, dispatch;
    logic [IDX_W-1:0] free_idx, sel_idx;

    assign RS_full  = &busy;
    assign ready    = busy & ~qj_busy & ~qk_busy;
    assign dispatch = ISSUE_sgn && free_vld;

    // Returns {still_pending, value}; LSB wins when both buses carry the tag.
    function automatic logic [32:0] snoop(input logic pend, input logic [ROB_W-1:0] q,
                                          input logic [31:0] v);
        if (pend && LSB_CDB_sgn && LSB_CDB_ROB_name == q) return {1'b0, LSB_CDB_result};
        if (pend && ALU_CDB_sgn && ALU_CDB_ROB_name == q) return {1'b0, ALU_CDB_result};
        return {pend, v};
    endfunction

    always_comb begin
        free_vld = 1'b0;
        free_idx = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (!busy[i]) begin
                free_vld = 1'b1;
                free_idx = IDX_W'(i);
            end
        end
    end

`ifdef RS_AGE_SELECT_EN
    // age[i][j] = entry i entered before entry j
    logic [RS_SIZE-1:0] age [RS_SIZE];

    always_comb begin
        sel_vld = 1'b0;
        sel_idx = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            if (ready[i] && ((age[i] | ~ready | (RS_SIZE'(1) << i)) == '1)) begin
                sel_vld = 1'b1;
                sel_idx = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RS_SIZE; i++) age[i] <= '0;
        end else if (rdy && !ROB_clear && dispatch) begin
            age[free_idx] <= '0;
            for (int j = 0; j < RS_SIZE; j++)
                if (busy[j]) age[j][free_idx] <= 1'b1;
        end
    end
`else
    always_comb begin
        sel_vld = 1'b0;
        sel_idx = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (ready[i]) begin
                sel_vld = 1'b1;
                sel_idx = IDX_W'(i);
            end
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            busy         <= '0;
            ALU_sgn      <= 1'b0;
            ALU_opcode   <= '0;
            ALU_ROB_name <= '0;
            ALU_lhs      <= '0;
            ALU_rhs      <= '0;
        end else if (!rdy) begin
            ALU_sgn <= 1'b0;
        end else if (ROB_clear) begin
            busy    <= '0;
            ALU_sgn <= 1'b0;
        end else begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (busy[i]) begin
                    {qj_busy[i], vj[i]} <= snoop(qj_busy[i], qj[i], vj[i]);
                    {qk_busy[i], vk[i]} <= snoop(qk_busy[i], qk[i], vk[i]);
                end
            end
            ALU_sgn <= sel_vld;
            if (sel_vld) begin
                ALU_opcode    <= op_q[sel_idx];
                ALU_ROB_name  <= rob_q[sel_idx];
                ALU_lhs       <= vj[sel_idx];
                ALU_rhs       <= vk[sel_idx];
                busy[sel_idx] <= 1'b0;
            end
            // Selected entry is ready (not free), so it never collides with the dispatch slot.
            if (dispatch) begin
                busy[free_idx]  <= 1'b1;
                op_q[free_idx]  <= ISSUE_opcode;
                rob_q[free_idx] <= ISSUE_ROB_name;
                qj[free_idx]    <= ISSUE_Qj;
                qk[free_idx]    <= ISSUE_Qk;
                {qj_busy[free_idx], vj[free_idx]} <= snoop(ISSUE_Qj_busy, ISSUE_Qj, ISSUE_Vj);
                {qk_busy[free_idx], vk[free_idx]} <= snoop(ISSUE_Qk_busy, ISSUE_Qk, ISSUE_Vk);
            end
        end
    end
endmodule

// File: tb/tb_rs_station.sv
// Directed bench for rs_station; every ALU issue is checked against a scoreboard queue.
module tb_rs_station;
    localparam int ROB_W = 4;
    localparam logic [5:0] ADD = 6'd1;
    localparam logic [5:0] SUB = 6'd2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, rdy, ISSUE_sgn, ISSUE_Qj_busy, ISSUE_Qk_busy, RS_full;
    logic [5:0] ISSUE_opcode, ALU_opcode;
    logic [ROB_W-1:0] ISSUE_ROB_name, ISSUE_Qj, ISSUE_Qk, ALU_CDB_ROB_name, LSB_CDB_ROB_name, ALU_ROB_name;
    logic [31:0] ISSUE_Vj, ISSUE_Vk, ALU_CDB_result, LSB_CDB_result, ALU_lhs, ALU_rhs;
    logic ALU_CDB_sgn, LSB_CDB_sgn, ROB_clear, ALU_sgn;

    rs_station #(.RS_SIZE(16), .ROB_W(ROB_W)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .ISSUE_sgn(ISSUE_sgn), .ISSUE_opcode(ISSUE_opcode), .ISSUE_ROB_name(ISSUE_ROB_name),
        .ISSUE_Vj(ISSUE_Vj), .ISSUE_Vk(ISSUE_Vk),
        .ISSUE_Qj_busy(ISSUE_Qj_busy), .ISSUE_Qk_busy(ISSUE_Qk_busy),
        .ISSUE_Qj(ISSUE_Qj), .ISSUE_Qk(ISSUE_Qk), .RS_full(RS_full),
        .ALU_CDB_sgn(ALU_CDB_sgn), .ALU_CDB_result(ALU_CDB_result), .ALU_CDB_ROB_name(ALU_CDB_ROB_name),
        .LSB_CDB_sgn(LSB_CDB_sgn), .LSB_CDB_result(LSB_CDB_result), .LSB_CDB_ROB_name(LSB_CDB_ROB_name),
        .ROB_clear(ROB_clear), .ALU_sgn(ALU_sgn), .ALU_opcode(ALU_opcode),
        .ALU_ROB_name(ALU_ROB_name), .ALU_lhs(ALU_lhs), .ALU_rhs(ALU_rhs)
    );

    typedef struct packed {
        logic [5:0]       op;
        logic [ROB_W-1:0] rob;
        logic [31:0]      lhs;
        logic [31:0]      rhs;
    } iss_t;

    iss_t exp_q[$];
    int n_assert = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [5:0] op, input logic [ROB_W-1:0] rob,
                        input logic [31:0] lhs, input logic [31:0] rhs);
        iss_t e;
        e.op = op; e.rob = rob; e.lhs = lhs; e.rhs = rhs;
        exp_q.push_back(e);
    endtask

    // One clock edge, then compare any issued op against the scoreboard head.
    task automatic step();
        iss_t e;
        @(posedge clk);
        #1;
        if (ALU_sgn === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_issue", {ALU_opcode, ALU_ROB_name, ALU_lhs, ALU_rhs}, 128'd0);
            end else begin
                e = exp_q.pop_front();
                chk("issue_fields", {ALU_opcode, ALU_ROB_name, ALU_lhs, ALU_rhs}, e);
            end
        end
    endtask

    task automatic idle();
        rdy = 1'b1; ISSUE_sgn = 1'b0; ALU_CDB_sgn = 1'b0; LSB_CDB_sgn = 1'b0; ROB_clear = 1'b0;
    endtask

    task automatic disp(input logic [5:0] op, input logic [ROB_W-1:0] rob,
                        input logic [31:0] vj, input logic qjb, input logic [ROB_W-1:0] qj,
                        input logic [31:0] vk, input logic qkb, input logic [ROB_W-1:0] qk);
        ISSUE_sgn = 1'b1; ISSUE_opcode = op; ISSUE_ROB_name = rob;
        ISSUE_Vj = vj; ISSUE_Qj_busy = qjb; ISSUE_Qj = qj;
        ISSUE_Vk = vk; ISSUE_Qk_busy = qkb; ISSUE_Qk = qk;
    endtask

    task automatic alu_cdb(input logic [ROB_W-1:0] tag, input logic [31:0] val);
        ALU_CDB_sgn = 1'b1; ALU_CDB_ROB_name = tag; ALU_CDB_result = val;
    endtask

    task automatic lsb_cdb(input logic [ROB_W-1:0] tag, input logic [31:0] val);
        LSB_CDB_sgn = 1'b1; LSB_CDB_ROB_name = tag; LSB_CDB_result = val;
    endtask

    initial begin
        idle();
        disp(ADD, 0, 0, 0, 0, 0, 0, 0);
        ISSUE_sgn = 1'b0;
        ALU_CDB_ROB_name = '0; ALU_CDB_result = '0; LSB_CDB_ROB_name = '0; LSB_CDB_result = '0;
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        chk("rst_sgn", ALU_sgn, 0);
        chk("rst_full", RS_full, 0);
        chk("rst_opcode", ALU_opcode, 0);
        chk("rst_rob", ALU_ROB_name, 0);
        chk("rst_lhs", ALU_lhs, 0);
        chk("rst_rhs", ALU_rhs, 0);

        // Ready ADD issues one cycle after dispatch
        disp(ADD, 4'd1, 32'd5, 0, 0, 32'd7, 0, 0);
        push(ADD, 4'd1, 32'd5, 32'd7);
        step(); idle();
        chk("add_not_same_cycle", ALU_sgn, 0);
        step();
        chk("add_issue", ALU_sgn, 1);
        step();
        chk("add_one_cycle", ALU_sgn, 0);

        // SUB waiting on tag 3, woken by ALU CDB
        disp(SUB, 4'd2, 32'd0, 1, 4'd3, 32'd1, 0, 0);
        step(); idle();
        chk("sub_wait", ALU_sgn, 0);
        alu_cdb(4'd3, 32'd10);
        push(SUB, 4'd2, 32'd10, 32'd1);
        step(); idle();
        chk("sub_not_early", ALU_sgn, 0);
        step();
        chk("sub_issue", ALU_sgn, 1);
        step();
        chk("sub_one_cycle", ALU_sgn, 0);

        // Dispatch-time capture; LSB wins over ALU on the same tag
        disp(ADD, 4'd3, 32'h11, 0, 0, 32'd0, 1, 4'd2);
        lsb_cdb(4'd2, 32'h80);
        alu_cdb(4'd2, 32'h55);
        push(ADD, 4'd3, 32'h11, 32'h80);
        step(); idle();
        step();
        chk("capture_issue", ALU_sgn, 1);
        step();

        // Fill, dropped 17th op, then flush
        for (int i = 0; i < 16; i++) begin
            disp(ADD, ROB_W'(i), 32'd0, 1, 4'd9, 32'd0, 0, 0);
            step(); idle();
            if (i == 14) chk("not_full_15", RS_full, 0);
        end
        chk("full_16", RS_full, 1);
        disp(SUB, 4'd15, 32'hAA, 0, 0, 32'hBB, 0, 0);
        step(); idle();
        chk("full_after_drop", RS_full, 1);
        step();
        ROB_clear = 1'b1;
        step(); idle();
        chk("flush_full", RS_full, 0);
        chk("flush_sgn", ALU_sgn, 0);
        alu_cdb(4'd9, 32'h99);
        step(); idle();
        step(); step(); step();
        chk("flush_no_issue", ALU_sgn, 0);

        // Age order: A in slot 5, B in slot 2, both woken by tag 4
        for (int i = 0; i < 5; i++) begin
            if (i == 2) disp(ADD, 4'd10, 32'd0, 1, 4'd6, 32'd0, 0, 0);
            else        disp(ADD, ROB_W'(11 + (i > 2 ? i - 1 : i)), 32'd0, 1, 4'd7, 32'd0, 0, 0);
            step(); idle();
        end
        disp(ADD, 4'd5, 32'd0, 1, 4'd4, 32'h20, 0, 0);
        step(); idle();
        alu_cdb(4'd6, 32'h66);
        push(ADD, 4'd10, 32'h66, 32'd0);
        step(); idle();
        step();
        chk("slot2_freed_issue", ALU_sgn, 1);
        disp(SUB, 4'd6, 32'd0, 1, 4'd4, 32'h30, 0, 0);
        step(); idle();
        alu_cdb(4'd4, 32'h40);
`ifdef RS_AGE_SELECT_EN
        push(ADD, 4'd5, 32'h40, 32'h20);
        push(SUB, 4'd6, 32'h40, 32'h30);
`else
        push(SUB, 4'd6, 32'h40, 32'h30);
        push(ADD, 4'd5, 32'h40, 32'h20);
`endif
        step(); idle();
        step();
        chk("age_first", ALU_sgn, 1);
        step();
        chk("age_second", ALU_sgn, 1);
        step();
        chk("age_done", ALU_sgn, 0);
        ROB_clear = 1'b1;
        step(); idle();

        // rdy freeze with a ready entry present
        disp(SUB, 4'd12, 32'h123, 0, 0, 32'h456, 0, 0);
        step(); idle();
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("freeze_sgn", ALU_sgn, 0);
        end
        rdy = 1'b1;
        push(SUB, 4'd12, 32'h123, 32'h456);
        step();
        chk("unfreeze_issue", ALU_sgn, 1);
        step();
        chk("unfreeze_once", ALU_sgn, 0);
        step();

        chk("scoreboard_drain", 128'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
